// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-side load/store controller in front of a synchronous 16-bit RAM.
//
// Accepts one request at a time on a valid/ready request channel and returns
// exactly one response on a valid/ready response channel. Word accesses
// need an even byte address. Byte stores are done as a read-modify-write,
// so the RAM byte enable is always 2'b11.
//
// Handshake rule: a transfer happens on the rising edge where valid && ready.
// The producer holds valid and its payload stable until that edge. The
// consumer may change ready at any time.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_byte     1 = store / 1 = byte access
//   req_addr, req_wdata  byte address, store data (byte stores use [7:0])
//   rsp_valid/rsp_ready  response handshake (valid only in RESP)
//   rsp_rdata, rsp_err   load data (byte loads zero-extended), reject flag
//   ram_addr, ram_wdata  RAM word index and write data
//   ram_be, ram_we       RAM byte enable (constant 2'b11), write strobe
//   ram_rdata            RAM read data, valid one clock after ram_addr
//   dbg_state            current FSM state, for observation
module mem_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [1:0]  ram_be,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic        r_byte;
  logic        r_lane;
  logic [15:0] r_wdata;
  logic [15:0] r_ram_addr;
  logic [15:0] r_ram_wdata;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic [15:0] w_idx;
  logic        w_err;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_idx    = {1'b0, req_addr[15:1]};
  // Misaligned word access or a word index past the end of the RAM.
  assign w_err    = (!req_byte && req_addr[0]) || (32'(w_idx) >= 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err)                   w_next = RESP;
          else if (req_we && !req_byte) w_next = WR;
          else                          w_next = RD_ADDR;
        end
      end
      RD_ADDR: w_next = RD_DATA;
      // Byte stores continue to the write; loads go straight to the response.
      RD_DATA: w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_lane      <= 1'b0;
      r_wdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= req_we;
        r_byte      <= req_byte;
        r_lane      <= req_addr[0];
        r_wdata     <= req_wdata;
        r_ram_addr  <= w_idx;
        r_rsp_rdata <= '0;
        r_rsp_err   <= w_err;
        if (req_we && !req_byte) r_ram_wdata <= req_wdata;
      end
      // ram_rdata holds the addressed word during RD_DATA.
      if (r_state == RD_DATA) begin
        if (r_we) begin
          // Merge the new byte into the word just read; the other lane is kept.
          r_ram_wdata <= r_lane ? {r_wdata[7:0], ram_rdata[7:0]}
                                : {ram_rdata[15:8], r_wdata[7:0]};
        end else if (r_byte) begin
          r_rsp_rdata <= {8'h00, (r_lane ? ram_rdata[15:8] : ram_rdata[7:0])};
        end else begin
          r_rsp_rdata <= ram_rdata;
        end
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_be    = 2'b11;
  assign ram_we    = (r_state == WR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural synchronous RAM, reference memory model,
// expected-response queue, directed steps plus a short random phase.
module tb_mem_ctrl;
  localparam int MEM_WORDS = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_be;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [2:0]  dbg_state;

  mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // behavioural RAM: registered read, write on strobe
  logic [15:0] ram [MEM_WORDS];
  logic [15:0] ref_mem [MEM_WORDS];
  int we_cnt = 0;
  int stab_bad = 0;
  logic [15:0] prev_addr = '0;
  logic [2:0]  prev_state = '0;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      if (32'(ram_addr) < MEM_WORDS) ram[ram_addr[7:0]] <= ram_wdata;
    end
    ram_rdata <= (32'(ram_addr) < MEM_WORDS) ? ram[ram_addr[7:0]] : 16'h0000;
  end

  // ram_addr must not move between the read phase and the write phase
  always @(posedge clk) begin
    if (rst_n && (dbg_state == 3'd2 || dbg_state == 3'd3) &&
        (prev_state == 3'd1 || prev_state == 3'd2) && ram_addr != prev_addr)
      stab_bad <= stab_bad + 1;
    prev_addr  <= ram_addr;
    prev_state <= dbg_state;
  end

  // scoreboard
  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one full request/response transaction, optional response stall
  task automatic do_req(input logic we, input logic byt, input logic [15:0] addr,
                        input logic [15:0] wd, input int hold, input string tag);
    logic [15:0] idx;
    logic        err;
    logic [15:0] exp_d;
    logic [16:0] e;
    int exp_lat, lat, n, we0;
    idx = {1'b0, addr[15:1]};
    err = (!byt && addr[0]) || (32'(idx) >= MEM_WORDS);
    exp_d = '0;
    if (err) begin
      exp_lat = 1;
    end else if (we) begin
      exp_lat = byt ? 4 : 2;
      if (!byt)        ref_mem[idx[7:0]] = wd;
      else if (addr[0]) ref_mem[idx[7:0]][15:8] = wd[7:0];
      else             ref_mem[idx[7:0]][7:0] = wd[7:0];
    end else begin
      exp_lat = 3;
      if (!byt)         exp_d = ref_mem[idx[7:0]];
      else if (addr[0]) exp_d = {8'h00, ref_mem[idx[7:0]][15:8]};
      else              exp_d = {8'h00, ref_mem[idx[7:0]][7:0]};
    end
    exp_q.push_back({err, exp_d});

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    we0 = we_cnt;
    @(posedge clk);
    #1;
    // scramble the request lines: the controller must use latched values
    req_valid = 1'b0; req_we = ~we; req_byte = ~byt;
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(e[16]));
    chk({tag, ":rsp_rdata"}, 32'(rsp_rdata), 32'(e[15:0]));
    if (!err) chk({tag, ":ram_addr"}, 32'(ram_addr), 32'(idx));
    chk({tag, ":we_count"}, 32'(we_cnt - we0), (we && !err) ? 32'd1 : 32'd0);

    if (hold > 0) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0003;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ":hold_rdata"}, 32'(rsp_rdata), 32'(e[15:0]));
        chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ":back_idle"}, 32'(dbg_state), 32'd0);
    if (hold > 0) begin
      // pending request only now sees req_ready; it was not taken earlier
      chk({tag, ":pending_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":state"}, 32'(dbg_state), 32'd0);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ":rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, ":ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, ":ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, ":ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, ":ram_be"}, 32'(ram_be), 32'd3);
  endtask

  initial begin
    int we0;
    logic        r_we_bit, r_byte_bit;
    logic [15:0] r_addr;

    #1;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // word store then load back
    do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0, "st_0010");
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 0, "ld_0010");

    // byte read-modify-write on the upper lane
    do_req(1'b1, 1'b0, 16'h0020, 16'h1234, 0, "st_0020");
    do_req(1'b1, 1'b1, 16'h0021, 16'h00AB, 0, "stb_0021");
    do_req(1'b0, 1'b0, 16'h0020, 16'h0000, 0, "ld_0020");
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, 0, "ldb_0020");
    do_req(1'b0, 1'b1, 16'h0021, 16'h0000, 0, "ldb_0021");

    // misaligned word access
    do_req(1'b0, 1'b0, 16'h0003, 16'h0000, 0, "ld_misalign");
    do_req(1'b1, 1'b0, 16'h0005, 16'hDEAD, 0, "st_misalign");

    // range boundary: last word valid, one past the end rejected
    do_req(1'b1, 1'b0, 16'h01FE, 16'h0F0F, 0, "st_last");
    do_req(1'b0, 1'b0, 16'h01FE, 16'h0000, 0, "ld_last");
    do_req(1'b0, 1'b0, 16'h0200, 16'h0000, 0, "ld_oor");
    do_req(1'b1, 1'b1, 16'h0201, 16'h0077, 0, "stb_oor");

    // response stall with a competing request waiting
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 5, "ld_hold");

    // random mix inside and just past the RAM
    for (int k = 0; k < 10; k++) begin
      r_we_bit   = 1'($urandom_range(0, 1));
      r_byte_bit = 1'($urandom_range(0, 1));
      r_addr     = 16'($urandom_range(0, 520));
      if (!r_byte_bit && $urandom_range(0, 3) != 0) r_addr[0] = 1'b0;
      do_req(r_we_bit, r_byte_bit, r_addr, 16'($urandom), 0, "rand");
    end

    // reset in the middle of a byte RMW leaves the word untouched
    do_req(1'b1, 1'b0, 16'h0040, 16'h5555, 0, "st_0040");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1;
    req_addr = 16'h0040; req_wdata = 16'h00FF;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw:rd_addr", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    chk("rmw:rd_data", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rmw_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rmw:no_write", 32'(we_cnt - we0), 32'd0);
    do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 0, "ld_0040");

    chk("addr_stable", 32'(stab_bad), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
